// File: rtl/mode_sequencer.sv
// Steps four mode blocks through PREP (reset pulse) and RUN (DWELL-cycle enable) visits, with registered outputs.
// Define MODE_SEQ_LOOP_EN to wrap from mode 3 back to mode 0 instead of returning to IDLE after one pass.
module mode_sequencer #(
    parameter int unsigned DWELL = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       next,
    input  logic [7:0] m1_out,
    input  logic [7:0] m2_out,
    input  logic [7:0] m3_out,
    input  logic [7:0] m4_out,
    output logic [3:0] en,
    output logic       mode_rst,
    output logic [7:0] OUT,
    output logic [1:0] mode_idx,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  m_sel;

    always_comb begin
        m_sel = 8'h00;
        case (mode_idx)
            2'd0:    m_sel = m1_out;
            2'd1:    m_sel = m2_out;
            2'd2:    m_sel = m3_out;
            default: m_sel = m4_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = mode_idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = PREP;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 16'd0;
                end
            end
            PREP: begin
                cnt_nxt = 16'd0;
                if (stop) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 16'd0;
                end else if (next || cnt == 16'(DWELL - 1)) begin
                    cnt_nxt = 16'd0;
                    idx_nxt = mode_idx + 2'd1;
                    if (mode_idx == 2'd3) begin
`ifdef MODE_SEQ_LOOP_EN
                        state_nxt = PREP;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = PREP;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 2'd0;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mode_idx <= 2'd0;
            cnt      <= 16'd0;
            en       <= 4'b0000;
            mode_rst <= 1'b0;
            OUT      <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_idx <= idx_nxt;
            cnt      <= cnt_nxt;
            en       <= (state_nxt == RUN) ? 4'(4'b0001 << idx_nxt) : 4'b0000;
            mode_rst <= (state_nxt == PREP);
            // OUT shows the previous RUN cycle's sample, so the first RUN cycle reads zero.
            OUT      <= (state == RUN && state_nxt == RUN) ? m_sel : 8'h00;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter DWELL, default 32, clock cycles each mode stays enabled per visit (legal 2..65535).
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  level-sampled request to begin the sequence from mode 0.
REQ-005 Port stop  input  1  level-sampled request to abort and return to idle.
REQ-006 Port next  input  1  manual advance to the following mode while running.
REQ-007 Ports m1_out, m2_out, m3_out, m4_out  input  8 each  LED buses returned by the four mode blocks.
REQ-008 Port en  output  4  one-hot enable to the mode blocks, bit i drives mode i+1.
REQ-009 Port mode_rst  output  1  one-cycle reset pulse to all mode blocks before each mode starts.
REQ-010 Port OUT  output  8  registered LED bus selected from the active mode.
REQ-011 Port mode_idx  output  2  index of the current or pending mode.
REQ-012 Port busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, PREP, RUN; all outputs registered.
REQ-014 IDLE: en=0, mode_rst=0, OUT=8'h00, busy=0; start=1 -> PREP with mode_idx=0.
REQ-015 PREP lasts exactly one cycle: mode_rst=1, en=0, OUT=8'h00; then -> RUN.
REQ-016 RUN: en=one-hot(mode_idx), mode_rst=0; dwell counter starts at 0, increments each cycle.
REQ-017 RUN ends when counter=DWELL-1, so en is high exactly DWELL cycles; then -> PREP with mode_idx+1.
REQ-018 OUT in RUN = m(mode_idx+1)_out sampled the previous cycle (one-cycle latency); OUT=8'h00 outside RUN.
REQ-019 next=1 in RUN -> PREP on the next edge with mode_idx+1, counter cleared; next ignored in IDLE and PREP.
REQ-020 stop=1 in any non-IDLE state -> IDLE on the next edge; en, OUT, mode_idx cleared.
REQ-021 Priority on the same cycle: reset > stop > next > dwell expiry > start.
REQ-022 start while busy is ignored; start and stop together in IDLE keep IDLE.
REQ-023 Leaving mode 3 (idx=3) is governed by REQ-028/029; mode_idx arithmetic is modulo 4.
REQ-024 en has at most one bit set in every cycle; en and mode_rst are never high together.

Reset
REQ-025 reset=1 at a clock edge forces IDLE, en=4'b0000, mode_rst=0, OUT=8'h00, mode_idx=0, busy=0, counter=0.
REQ-026 Reset mid-RUN or mid-PREP takes effect on that edge; no further mode_rst pulse is issued.
REQ-027 After reset release, the block stays in IDLE until start is sampled high.

Configuration
REQ-028 With MODE_SEQ_LOOP_EN defined: expiry or next in mode 3 -> PREP with mode_idx=0, looping until stop or reset.
REQ-029 Without MODE_SEQ_LOOP_EN: expiry or next in mode 3 -> IDLE (busy=0, en=0) after one full pass.

Verification (DWELL=4)
REQ-030 reset pulse, then start one cycle -> PREP one cycle with mode_rst=1, then en=0001 for exactly 4 cycles, then mode_rst pulse, then en=0010.
REQ-031 m1_out=8'hAA held constant during mode 0 -> OUT=8'hAA from the second RUN cycle onward, 8'h00 during PREP.
REQ-032 Full pass without macro -> en sequence 0001,0010,0100,1000, then IDLE with busy=0; with macro -> en=0001 again after the mode 3 PREP.
REQ-033 next asserted on the 2nd RUN cycle of mode 0 -> PREP next edge, mode_idx=1, en=0010 for a full 4 cycles.
REQ-034 stop and next asserted together in RUN mode 2 -> IDLE, en=0000, OUT=8'h00, mode_idx=0.
REQ-035 reset asserted in RUN mode 1 -> all outputs zero on that edge; start while busy mid-mode 0 -> no restart, counter unaffected.
